radio_ramp_seq: RTL
===================

# radio_ramp_seq

Radio ramp sequencer downstream of the timing-engine stages. Consumes `radioEnable`, `radioRxEn` and `pllSettled` from the timing-engine interface and produces the timed front-end enables for the radio (LNA/PA ramp, RX/TX active). It sits in its own power domain, so all inputs are clamped when the upstream domain is isolated.

## Interface
- `RAMP_CYCLES`, 16: cycles of LNA/PA ramp before active; ≥1.
- `RAMPDN_CYCLES`, 4: cycles LNA/PA stay on after active drops; ≥1.
- `PLL_TIMEOUT`, 255: max cycles waiting for `pllSettled`; ≥1.
- `ck` input 1: clock; single clock domain.
- `arst` input 1: reset, asynchronous, active-low.
- `isolate` input 1: upstream isolation; 1 clamps `radioEnable`, `radioRxEn` and `pllSettled` to 0.
- `radioEnable` input 1: request radio on (level).
- `radioRxEn` input 1: mode, 1 = RX, 0 = TX; sampled at enable.
- `pllSettled` input 1: PLL lock (level).
- `clrErr` input 1: single-cycle pulse, clears `pllErr`.
- `lnaEn` output 1: LNA enable (RX ramp/active/ramp-down).
- `paEn` output 1: PA enable (TX ramp/active/ramp-down).
- `rxActive` output 1: RX path ready.
- `txActive` output 1: TX path ready.
- `busy` output 1: state ≠ IDLE.
- `pllErr` output 1: sticky; PLL timeout or lock loss.

## Operation
- `en` = `radioEnable & ~isolate`; `pll` = `pllSettled & ~isolate`; `rx` = `radioRxEn & ~isolate`.
- States: IDLE, WAIT_PLL, RAMP, ACTIVE, RAMP_DN. Counter `cnt` is reset to 0 on every state entry.
- IDLE: when `en` is 1, latch `modeRx` ← `rx` and go to WAIT_PLL.
- WAIT_PLL: `en` = 0 → IDLE. Else `pll` = 1 → RAMP. Else, when `cnt` = PLL_TIMEOUT−1, set `pllErr` and go to IDLE. Else `cnt`++.
- RAMP: `en` = 0 or `pll` = 0 → RAMP_DN; a `pll` drop also sets `pllErr`. Else, when `cnt` = RAMP_CYCLES−1, go to ACTIVE. Else `cnt`++.
- ACTIVE: `en` = 0 or `pll` = 0 → RAMP_DN; a `pll` drop also sets `pllErr`. A change of `radioRxEn` while in ACTIVE is ignored.
- RAMP_DN: inputs are ignored. When `cnt` = RAMPDN_CYCLES−1, go to IDLE. Else `cnt`++.
- Re-enable during RAMP_DN: the ramp-down completes, IDLE is entered, and `en` is sampled on the next edge.
- Output decode:
  - `lnaEn` = `modeRx` & state ∈ {RAMP, ACTIVE, RAMP_DN}.
  - `paEn` = `~modeRx` & same states.
  - `rxActive`/`txActive` = ACTIVE & `modeRx`/`~modeRx`.
  - `busy` = state ≠ IDLE.
- `pllErr`: a set and `clrErr` in the same cycle → set wins. `clrErr` in any state clears `pllErr` and has no other effect.
- Counter width = `$clog2(max(PLL_TIMEOUT, RAMP_CYCLES, RAMPDN_CYCLES))`, minimum 1; no wrap is reachable.

## Timing
- All outputs are decoded from flops only (state, `modeRx`, `pllErr`); no combinational input→output path.
- Reset (`arst` = 0): state IDLE, `cnt` 0, `modeRx` 0, `pllErr` 0. All outputs are 0 during reset and in the first cycle after release.
- `en` sampled at edge E0 with `pll` already 1:
  - WAIT_PLL after E0.
  - RAMP after E1: `lnaEn`/`paEn` = 1.
  - ACTIVE after E1+RAMP_CYCLES.
- RAMP_DN duration is exactly RAMPDN_CYCLES cycles. IDLE is entered RAMPDN_CYCLES edges after RAMP_DN entry.
- PLL timeout: IDLE and `pllErr` = 1 after edge PLL_TIMEOUT following WAIT_PLL entry.
- `isolate` rising mid-operation behaves as `en` = `pll` = 0 that cycle:
  - From WAIT_PLL → IDLE, no error.
  - From RAMP/ACTIVE → RAMP_DN with `pllErr` set.
- `arst` asserted mid-operation forces IDLE immediately and asynchronously; all outputs drop without ramp-down.

## Structure
- Package `radio_seq_pkg`: `state_t` enum (IDLE, WAIT_PLL, RAMP, ACTIVE, RAMP_DN) and default constants for RAMP_CYCLES, RAMPDN_CYCLES and PLL_TIMEOUT.
- One sub-module `radio_iso_clamp`: combinational AND-clamp of the three inputs with `isolate`. It is instantiated at the block boundary so that UPF isolation cells map onto it.
- FSM, counter and error flag live in `radio_ramp_seq`.

## Test plan
- RX nominal (RAMP_CYCLES = 16):
  - Stimulus: `pll` = 1, `radioRxEn` = 1, raise `radioEnable` before E0.
  - Response: `lnaEn` = 1 after E1; `rxActive` = 1 after E17; `paEn`/`txActive` stay 0.
  - Dropping enable at E30 → `rxActive` 0 after E30; `lnaEn` 0 after E34; `busy` 0 after E34.
- PLL timeout (PLL_TIMEOUT = 255):
  - Stimulus: `pll` = 0, enable held.
  - Response: IDLE and `pllErr` = 1 after edge 256.
  - `clrErr` pulse → `pllErr` 0. `clrErr` together with a timeout in the same cycle → `pllErr` 1.
- Lock loss: TX in ACTIVE, drop `pllSettled` → `txActive` 0 next edge, `pllErr` 1, `paEn` low 4 cycles later.
- Isolation mid-RAMP: assert `isolate` → RAMP_DN and `pllErr` 1. Re-raising `radioEnable` during RAMP_DN has no effect until IDLE.
- Mode change in ACTIVE: toggle `radioRxEn` while RX ACTIVE → outputs unchanged.
- Async reset mid-ACTIVE: `arst` = 0 → all outputs 0 without waiting for a clock edge; IDLE after release.

Source files
------------

// File: rtl/radio_seq_pkg.sv
// Shared types and defaults for the radio ramp sequencer.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package radio_seq_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_PLL = 3'd1,
      RAMP     = 3'd2,
      ACTIVE   = 3'd3,
      RAMP_DN  = 3'd4
   } state_t;

   localparam int RAMP_CYCLES_DEF   = 16;
   localparam int RAMPDN_CYCLES_DEF = 4;
   localparam int PLL_TIMEOUT_DEF   = 255;

   // Width of the shared state counter. It only ever has to reach
   // (limit - 1) for the largest limit, so clog2 of that limit is enough.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      int w;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      w = $clog2(m);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/radio_iso_clamp.sv
// Purpose: AND-clamps the upstream control inputs while the upstream domain is isolated.
// Latency: combinational, no flops.
// Backpressure: none; level signals only.
// Ports: isolate (1 = clamp), radioEnable/radioRxEn/pllSettled (raw) -> en/rx/pll (clamped).
// Kept as its own module at the block boundary so isolation cells map onto it.
module radio_iso_clamp (
   input  logic isolate,
   input  logic radioEnable,
   input  logic radioRxEn,
   input  logic pllSettled,
   output logic en,
   output logic rx,
   output logic pll
);

   assign en  = radioEnable & ~isolate;
   assign rx  = radioRxEn   & ~isolate;
   assign pll = pllSettled  & ~isolate;

endmodule

// File: rtl/radio_ramp_seq.sv
// Purpose: sequences radio front-end enables (PLL wait, LNA/PA ramp, active, ramp-down).
// Latency: outputs are flop-decoded; first ramp enable two edges after enable is sampled with PLL locked.
// Backpressure: none; level-driven, inputs ignored during ramp-down.
// Ports: ck, arst (async, active-low); isolate, radioEnable, radioRxEn, pllSettled, clrErr in;
//        lnaEn, paEn, rxActive, txActive, busy, pllErr out.
module radio_ramp_seq
   import radio_seq_pkg::*;
#(
   parameter int RAMP_CYCLES   = RAMP_CYCLES_DEF,
   parameter int RAMPDN_CYCLES = RAMPDN_CYCLES_DEF,
   parameter int PLL_TIMEOUT   = PLL_TIMEOUT_DEF
) (
   input  logic ck,
   input  logic arst,
   input  logic isolate,
   input  logic radioEnable,
   input  logic radioRxEn,
   input  logic pllSettled,
   input  logic clrErr,
   output logic lnaEn,
   output logic paEn,
   output logic rxActive,
   output logic txActive,
   output logic busy,
   output logic pllErr
);

   localparam int CW = cnt_width(PLL_TIMEOUT, RAMP_CYCLES, RAMPDN_CYCLES);

   localparam logic [CW-1:0] PLL_LAST    = CW'(PLL_TIMEOUT - 1);
   localparam logic [CW-1:0] RAMP_LAST   = CW'(RAMP_CYCLES - 1);
   localparam logic [CW-1:0] RAMPDN_LAST = CW'(RAMPDN_CYCLES - 1);

   logic en;
   logic rx;
   logic pll;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          mode_rx;
   logic          mode_rx_nxt;
   logic          set_err;

   radio_iso_clamp u_clamp (
      .isolate     (isolate),
      .radioEnable (radioEnable),
      .radioRxEn   (radioRxEn),
      .pllSettled  (pllSettled),
      .en          (en),
      .rx          (rx),
      .pll         (pll)
   );

   always_ff @(posedge ck or negedge arst) begin
      if (!arst) begin
         state   <= IDLE;
         cnt     <= '0;
         mode_rx <= 1'b0;
         pllErr  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         mode_rx <= mode_rx_nxt;
         // A new error outranks a simultaneous clear.
         if (set_err)
            pllErr <= 1'b1;
         else if (clrErr)
            pllErr <= 1'b0;
      end
   end

   always_comb begin
      state_nxt   = state;
      mode_rx_nxt = mode_rx;
      set_err     = 1'b0;

      unique case (state)
         IDLE: begin
            if (en) begin
               mode_rx_nxt = rx;
               state_nxt   = WAIT_PLL;
            end
         end
         WAIT_PLL: begin
            if (!en) begin
               state_nxt = IDLE;
            end else if (pll) begin
               state_nxt = RAMP;
            end else if (cnt == PLL_LAST) begin
               set_err   = 1'b1;
               state_nxt = IDLE;
            end
         end
         RAMP: begin
            if (!en || !pll) begin
               set_err   = ~pll;
               state_nxt = RAMP_DN;
            end else if (cnt == RAMP_LAST) begin
               state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            if (!en || !pll) begin
               set_err   = ~pll;
               state_nxt = RAMP_DN;
            end
         end
         RAMP_DN: begin
            if (cnt == RAMPDN_LAST)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // Counter restarts on every state change and otherwise counts; in IDLE
      // and ACTIVE it is never examined, so it is simply held at zero there.
      if (state_nxt != state || state == IDLE || state == ACTIVE)
         cnt_nxt = '0;
      else
         cnt_nxt = cnt + 1'b1;
   end

   logic on_state;
   assign on_state = (state == RAMP) || (state == ACTIVE) || (state == RAMP_DN);

   assign lnaEn    = on_state &  mode_rx;
   assign paEn     = on_state & ~mode_rx;
   assign rxActive = (state == ACTIVE) &  mode_rx;
   assign txActive = (state == ACTIVE) & ~mode_rx;
   assign busy     = (state != IDLE);

endmodule
